// File: rtl/aes_seq_ctrl_if.sv
// rtl/aes_seq_ctrl_if.sv - host and AES core signal bundle for aes_seq_ctrl
interface aes_seq_ctrl_if;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_inv;
   logic [1:0]   cmd_nk;
   logic [7:0]   cmd_nblk;
   logic         key_valid;
   logic         key_ready;
   logic [31:0]  key_w;
   logic         blk_valid;
   logic         blk_ready;
   logic [127:0] blk_data;
   logic         res_valid;
   logic         res_last;
   logic [127:0] res_data;
   logic         busy;
   logic         err;
   logic         aes_inv_valid;
   logic         aes_inv;
   logic         aes_nk_valid;
   logic [1:0]   aes_nk;
   logic         aes_key_expand;
   logic         aes_key_valid;
   logic [31:0]  aes_key_w;
   logic         aes_pct_first_flag;
   logic [127:0] aes_pct;
   logic         aes_key_expand_done;
   logic         aes_out_pct_valid;
   logic         aes_out_pct_last_flag;
   logic [127:0] aes_out_pct;

   // controller view
   modport slave (
      input  cmd_valid, cmd_inv, cmd_nk, cmd_nblk, key_valid, key_w, blk_valid, blk_data,
             aes_key_expand_done, aes_out_pct_valid, aes_out_pct_last_flag, aes_out_pct,
      output cmd_ready, key_ready, blk_ready, res_valid, res_last, res_data, busy, err,
             aes_inv_valid, aes_inv, aes_nk_valid, aes_nk, aes_key_expand, aes_key_valid,
             aes_key_w, aes_pct_first_flag, aes_pct
   );

   // host plus core view
   modport master (
      output cmd_valid, cmd_inv, cmd_nk, cmd_nblk, key_valid, key_w, blk_valid, blk_data,
             aes_key_expand_done, aes_out_pct_valid, aes_out_pct_last_flag, aes_out_pct,
      input  cmd_ready, key_ready, blk_ready, res_valid, res_last, res_data, busy, err,
             aes_inv_valid, aes_inv, aes_nk_valid, aes_nk, aes_key_expand, aes_key_valid,
             aes_key_w, aes_pct_first_flag, aes_pct
   );
endinterface

// File: rtl/aes_seq_ctrl.sv
// rtl/aes_seq_ctrl.sv - job sequencer for an AES core: config, key load, expansion wait, block stream
module aes_seq_ctrl #(
   parameter int KE_TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          rst,
   aes_seq_ctrl_if.slave bus
);
   localparam int KW_W = (KE_TIMEOUT > 1) ? $clog2(KE_TIMEOUT) : 1;
   localparam logic [KW_W-1:0] KW_LAST = KW_W'(KE_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, CFG, KSTART, KLOAD, KWAIT, RUN, DRAIN} state_t;

   state_t         state;
   state_t         state_nx;
   logic           inv_q;
   logic [1:0]     nk_q;
   logic [7:0]     nblk_q;
   logic [3:0]     kcnt;
   logic [3:0]     kwords;
   logic [KW_W-1:0] kw_cnt;
   logic [7:0]     issued;
   logic [7:0]     completed;
   logic           inflight;
   logic           err_q;
   logic           res_valid_q;
   logic           res_last_q;
   logic [127:0]   res_data_q;
   logic           pct_first_q;
   logic [127:0]   pct_q;

   logic cmd_hs;
   logic key_hs;
   logic kw_last;
   logic blk_rdy;
   logic blk_hs;
   logic core_res;
   logic res_take;
   logic res_final;
   logic stray;
   logic ke_expire;

   always_comb begin
      case (nk_q)
         2'd0:    kwords = 4'd4;
         2'd1:    kwords = 4'd6;
         default: kwords = 4'd8;
      endcase
   end

   assign cmd_hs    = (state == IDLE) && bus.cmd_valid;
   assign key_hs    = (state == KLOAD) && bus.key_valid;
   assign kw_last   = key_hs && (kcnt == kwords - 4'd1);
   assign blk_rdy   = (state == RUN) && !inflight && (issued < nblk_q);
   assign blk_hs    = blk_rdy && bus.blk_valid;
   assign core_res  = bus.aes_out_pct_valid && bus.aes_out_pct_last_flag;
   assign res_take  = core_res && inflight;
   // a result arriving with no block outstanding cannot be attributed to the job
   assign stray     = core_res && !inflight;
   assign res_final = res_take && (completed + 8'd1 == nblk_q);
   assign ke_expire = (state == KWAIT) && !bus.aes_key_expand_done && (kw_cnt == KW_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (bus.cmd_valid && (bus.cmd_nk != 2'd3)) state_nx = CFG;
         end
         CFG:    state_nx = KSTART;
         KSTART: state_nx = KLOAD;
         KLOAD: begin
            if (kw_last) state_nx = KWAIT;
         end
         KWAIT: begin
            if (bus.aes_key_expand_done) state_nx = (nblk_q != 8'd0) ? RUN : IDLE;
            else if (ke_expire)          state_nx = IDLE;
         end
         RUN: begin
            if (blk_hs && (issued + 8'd1 == nblk_q)) state_nx = DRAIN;
         end
         DRAIN: begin
            if (res_final) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inv_q       <= 1'b0;
         nk_q        <= 2'd0;
         nblk_q      <= 8'd0;
         kcnt        <= 4'd0;
         kw_cnt      <= '0;
         issued      <= 8'd0;
         completed   <= 8'd0;
         inflight    <= 1'b0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
         res_data_q  <= '0;
         pct_first_q <= 1'b0;
         pct_q       <= '0;
      end else begin
         if (cmd_hs) begin
            inv_q     <= bus.cmd_inv;
            nk_q      <= bus.cmd_nk;
            nblk_q    <= bus.cmd_nblk;
            issued    <= 8'd0;
            completed <= 8'd0;
         end else begin
            if (blk_hs)   issued    <= issued + 8'd1;
            if (res_take) completed <= completed + 8'd1;
         end

         if (state != KLOAD) kcnt <= 4'd0;
         else if (key_hs)    kcnt <= kcnt + 4'd1;

         if (state != KWAIT) kw_cnt <= '0;
         else                kw_cnt <= kw_cnt + KW_W'(1);

         if (blk_hs)        inflight <= 1'b1;
         else if (res_take) inflight <= 1'b0;

         if (stray || ke_expire) err_q <= 1'b1;
         else if (cmd_hs)        err_q <= (bus.cmd_nk == 2'd3);

         res_valid_q <= res_take;
         res_last_q  <= res_final;
         if (res_take) res_data_q <= bus.aes_out_pct;

         pct_first_q <= blk_hs;
         if (blk_hs) pct_q <= bus.blk_data;
      end
   end

   assign bus.cmd_ready          = (state == IDLE);
   assign bus.busy               = (state != IDLE);
   assign bus.err                = err_q;
   assign bus.key_ready          = (state == KLOAD);
   assign bus.blk_ready          = blk_rdy;
   assign bus.res_valid          = res_valid_q;
   assign bus.res_last           = res_last_q;
   assign bus.res_data           = res_data_q;
   // config fields are only presented while their valids are up
   assign bus.aes_inv_valid      = (state == CFG);
   assign bus.aes_nk_valid       = (state == CFG);
   assign bus.aes_inv            = (state == CFG) && inv_q;
   assign bus.aes_nk             = (state == CFG) ? nk_q : 2'd0;
   assign bus.aes_key_expand     = (state == KSTART);
   assign bus.aes_key_valid      = key_hs;
   assign bus.aes_key_w          = key_hs ? bus.key_w : 32'd0;
   assign bus.aes_pct_first_flag = pct_first_q;
   assign bus.aes_pct            = pct_q;
endmodule

// File: tb/tb_aes_seq_ctrl.sv
// tb/tb_aes_seq_ctrl.sv - randomized self-checking bench for aes_seq_ctrl
module tb_aes_seq_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   aes_seq_ctrl_if cif();
   aes_seq_ctrl_if tif();

   aes_seq_ctrl dut (.clk(clk), .rst(rst), .bus(cif));
   aes_seq_ctrl #(.KE_TIMEOUT(15)) dut_to (.clk(clk), .rst(rst), .bus(tif));

   always #5 clk = ~clk;

   localparam logic [127:0] MASK = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

   int           n_cfg, n_kexp, n_core, n_cmd_bad;
   logic         cfg_inv;
   logic [1:0]   cfg_nk;
   logic [127:0] res_q[$];
   bit           last_q[$];
   logic [31:0]  kw_q[$];
   int           hs_res_q[$];
   logic [127:0] exp_q[$];
   logic [31:0]  key_sent_q[$];

   // results are pushed before handshakes so a handshake sees results already delivered
   always @(negedge clk) begin
      if (cif.aes_inv_valid) begin
         n_cfg++;
         cfg_inv = cif.aes_inv;
         cfg_nk  = cif.aes_nk;
      end
      if (cif.aes_key_expand) n_kexp++;
      if (cif.aes_inv_valid || cif.aes_nk_valid || cif.aes_key_expand || cif.aes_key_valid ||
          cif.aes_pct_first_flag || cif.aes_inv || (cif.aes_nk != 2'd0)) n_core++;
      if (cif.aes_key_valid) kw_q.push_back(cif.aes_key_w);
      if (cif.res_valid) begin
         res_q.push_back(cif.res_data);
         last_q.push_back(cif.res_last);
      end
      if (cif.blk_valid && cif.blk_ready) hs_res_q.push_back(res_q.size());
      if (cif.busy && cif.cmd_ready) n_cmd_bad++;
   end

   // behavioural AES core: one result per block, random latency, result = block ^ MASK
   int           core_cnt = 0;
   logic [127:0] pend;
   bit           stray_req = 0;
   always @(posedge clk) begin
      #1;
      cif.aes_out_pct_valid     = 1'b0;
      cif.aes_out_pct_last_flag = 1'b0;
      if (rst) begin
         core_cnt = 0;
      end else if (stray_req) begin
         stray_req = 0;
         cif.aes_out_pct_valid     = 1'b1;
         cif.aes_out_pct_last_flag = 1'b1;
         cif.aes_out_pct           = {$urandom, $urandom, $urandom, $urandom};
      end else if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            cif.aes_out_pct_valid     = 1'b1;
            cif.aes_out_pct_last_flag = 1'b1;
            cif.aes_out_pct           = pend ^ MASK;
         end
      end else if (cif.aes_pct_first_flag) begin
         pend     = cif.aes_pct;
         core_cnt = $urandom_range(1, 4);
      end
   end

   task clear_mon();
      n_cfg = 0; n_kexp = 0; n_core = 0; n_cmd_bad = 0;
      cfg_inv = 1'b0; cfg_nk = 2'd0;
      res_q.delete(); last_q.delete(); kw_q.delete(); hs_res_q.delete();
      exp_q.delete(); key_sent_q.delete();
   endtask

   task bound_fail(input string what);
      checks++;
      errors++;
      $display("FAIL bound_%s: wait expired, handshake never happened", what);
   endtask

   task run_job(input bit inv, input logic [1:0] nk, input logic [7:0] nblk, input int ke_delay,
                input bit hold, input bit poke, input int stop_keys);
      int nw;
      int t;
      clear_mon();
      @(posedge clk); #1;
      cif.cmd_valid = 1'b1; cif.cmd_inv = inv; cif.cmd_nk = nk; cif.cmd_nblk = nblk;
      t = 0;
      do begin @(negedge clk); t++; end while (!cif.cmd_ready && t < 50);
      if (!cif.cmd_ready) bound_fail("cmd");
      @(posedge clk); #1;
      cif.cmd_valid = 1'b0;
      if (nk == 2'd3) begin
         repeat (3) @(negedge clk);
         return;
      end
      nw = (nk == 2'd0) ? 4 : (nk == 2'd1) ? 6 : 8;
      for (int i = 0; i < nw; i++) begin
         if (i == stop_keys) return;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         cif.key_valid = 1'b1;
         cif.key_w     = $urandom;
         key_sent_q.push_back(cif.key_w);
         t = 0;
         do begin @(negedge clk); t++; end while (!cif.key_ready && t < 50);
         if (!cif.key_ready) bound_fail("key");
         @(posedge clk); #1;
         cif.key_valid = 1'b0;
      end
      repeat (ke_delay) @(posedge clk);
      #1 cif.aes_key_expand_done = 1'b1;
      @(posedge clk); #1;
      cif.aes_key_expand_done = 1'b0;
      for (int b = 0; b < nblk; b++) begin
         if (!hold || b == 0) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         cif.blk_valid = 1'b1;
         cif.blk_data  = {$urandom, $urandom, $urandom, $urandom};
         exp_q.push_back(cif.blk_data ^ MASK);
         t = 0;
         do begin @(negedge clk); t++; end while (!cif.blk_ready && t < 100);
         if (!cif.blk_ready) bound_fail("blk");
         @(posedge clk); #1;
         if (poke && b == 0) begin
            cif.cmd_valid = 1'b1;
            cif.cmd_nk    = 2'd3;
         end
         if (!hold || b == nblk - 1) cif.blk_valid = 1'b0;
      end
      cif.cmd_valid = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (cif.busy && t < 2000);
      if (cif.busy) bound_fail("idle");
      repeat (3) @(negedge clk);
   endtask

   task test_reset();
      rst = 1'b1;
      #2;
      checks++; if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cif.cmd_ready); end
      checks++; if (cif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", cif.busy); end
      checks++; if (cif.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", cif.err); end
      checks++; if ({cif.res_valid, cif.res_last, cif.key_ready, cif.blk_ready} !== 4'b0) begin
         errors++; $display("FAIL rst_outs: got %b want 0000", {cif.res_valid, cif.res_last, cif.key_ready, cif.blk_ready}); end
      checks++; if ({cif.aes_inv_valid, cif.aes_nk_valid, cif.aes_key_expand, cif.aes_pct_first_flag} !== 4'b0) begin
         errors++; $display("FAIL rst_core: got %b want 0000", {cif.aes_inv_valid, cif.aes_nk_valid, cif.aes_key_expand, cif.aes_pct_first_flag}); end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (cif.cmd_ready !== 1'b1 || cif.res_data !== 128'd0) begin
         errors++; $display("FAIL post_rst: cmd_ready %b res_data %h want 1 / 0", cif.cmd_ready, cif.res_data); end
   endtask

   task test_basic();
      run_job(1'b0, 2'd0, 8'd2, 20, 1'b0, 1'b0, -1);
      checks++; if (n_cfg !== 1) begin errors++; $display("FAIL basic_cfg: got %0d want 1", n_cfg); end
      checks++; if (n_kexp !== 1) begin errors++; $display("FAIL basic_kexp: got %0d want 1", n_kexp); end
      checks++; if (kw_q.size() !== 4) begin errors++; $display("FAIL basic_keys: got %0d want 4", kw_q.size()); end
      checks++; if (res_q.size() !== 2) begin errors++; $display("FAIL basic_res: got %0d want 2", res_q.size()); end
      if (res_q.size() == 2) begin
         checks++; if (last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin
            errors++; $display("FAIL basic_last: got %b%b want 01", last_q[0], last_q[1]); end
         checks++; if (res_q[1] !== exp_q[1]) begin errors++; $display("FAIL basic_data: got %h want %h", res_q[1], exp_q[1]); end
      end
      checks++; if (cif.err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", cif.err); end
   endtask

   task test_key_only();
      run_job(1'b1, 2'd2, 8'd0, 5, 1'b0, 1'b0, -1);
      checks++; if (kw_q.size() !== 8) begin errors++; $display("FAIL keyonly_keys: got %0d want 8", kw_q.size()); end
      checks++; if (hs_res_q.size() !== 0 || res_q.size() !== 0) begin
         errors++; $display("FAIL keyonly_blocks: hs %0d res %0d want 0 0", hs_res_q.size(), res_q.size()); end
      checks++; if (cif.err !== 1'b0 || cif.cmd_ready !== 1'b1) begin
         errors++; $display("FAIL keyonly_idle: err %b cmd_ready %b want 0 1", cif.err, cif.cmd_ready); end
   endtask

   task test_bad_nk();
      run_job(1'b1, 2'd3, 8'd4, 0, 1'b0, 1'b0, -1);
      checks++; if (cif.err !== 1'b1) begin errors++; $display("FAIL badnk_err: got %b want 1", cif.err); end
      checks++; if (n_core !== 0) begin errors++; $display("FAIL badnk_core: got %0d pulse cycles want 0", n_core); end
      checks++; if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL badnk_ready: got %b want 1", cif.cmd_ready); end
      run_job(1'b1, 2'd0, 8'd1, 3, 1'b0, 1'b0, -1);
      checks++; if (cif.err !== 1'b0) begin errors++; $display("FAIL badnk_clear: got %b want 0", cif.err); end
      checks++; if (cfg_inv !== 1'b1) begin errors++; $display("FAIL badnk_inv: got %b want 1", cfg_inv); end
   endtask

   task test_stray();
      clear_mon();
      @(posedge clk); #1;
      stray_req = 1;
      repeat (4) @(negedge clk);
      checks++; if (cif.err !== 1'b1) begin errors++; $display("FAIL stray_err: got %b want 1", cif.err); end
      checks++; if (res_q.size() !== 0) begin errors++; $display("FAIL stray_res: got %0d want 0", res_q.size()); end
   endtask

   task test_random();
      for (int it = 0; it < 5; it++) begin
         logic [1:0] nk;
         bit         inv;
         logic [7:0] nblk;
         int         nw;
         nk   = 2'($urandom_range(0, 2));
         inv  = 1'($urandom_range(0, 1));
         nblk = 8'($urandom_range(1, 6));
         nw   = 4 + 2 * int'(nk);
         run_job(inv, nk, nblk, $urandom_range(1, 30), 1'b0, 1'b0, -1);
         checks++; if (cfg_nk !== nk || cfg_inv !== inv || n_cfg !== 1) begin
            errors++; $display("FAIL rnd_cfg: nk %0d inv %b n %0d want %0d %b 1", cfg_nk, cfg_inv, n_cfg, nk, inv); end
         checks++; if (kw_q.size() !== nw) begin errors++; $display("FAIL rnd_nkeys: got %0d want %0d", kw_q.size(), nw); end
         for (int i = 0; i < kw_q.size() && i < key_sent_q.size(); i++) begin
            checks++; if (kw_q[i] !== key_sent_q[i]) begin
               errors++; $display("FAIL rnd_key%0d: got %h want %h", i, kw_q[i], key_sent_q[i]); end
         end
         checks++; if (res_q.size() !== int'(nblk)) begin errors++; $display("FAIL rnd_nres: got %0d want %0d", res_q.size(), nblk); end
         for (int i = 0; i < res_q.size() && i < exp_q.size(); i++) begin
            checks++; if (res_q[i] !== exp_q[i] || last_q[i] !== (i == int'(nblk) - 1)) begin
               errors++; $display("FAIL rnd_res%0d: got %h/%b want %h/%b", i, res_q[i], last_q[i], exp_q[i], i == int'(nblk) - 1); end
         end
         checks++; if (cif.err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b want 0", cif.err); end
      end
   endtask

   task test_back_to_back();
      run_job(1'b0, 2'd1, 8'd4, 7, 1'b1, 1'b1, -1);
      checks++; if (hs_res_q.size() !== 4) begin errors++; $display("FAIL b2b_hs: got %0d want 4", hs_res_q.size()); end
      for (int k = 0; k < hs_res_q.size(); k++) begin
         checks++; if (hs_res_q[k] !== k) begin
            errors++; $display("FAIL b2b_order%0d: results before accept %0d want %0d", k, hs_res_q[k], k); end
      end
      checks++; if (n_cfg !== 1 || n_cmd_bad !== 0 || cif.err !== 1'b0) begin
         errors++; $display("FAIL b2b_cmd: cfg %0d bad %0d err %b want 1 0 0", n_cfg, n_cmd_bad, cif.err); end
      checks++; if (res_q.size() !== 4) begin errors++; $display("FAIL b2b_res: got %0d want 4", res_q.size()); end
   endtask

   task test_reset_mid();
      run_job(1'b1, 2'd1, 8'd2, 0, 1'b0, 1'b0, 3);
      rst = 1'b1;
      #1;
      checks++; if (cif.busy !== 1'b0 || cif.cmd_ready !== 1'b1 || cif.key_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_state: busy %b cmd_ready %b key_ready %b want 0 1 0", cif.busy, cif.cmd_ready, cif.key_ready); end
      checks++; if (kw_q.size() !== 3) begin errors++; $display("FAIL midrst_keys: got %0d want 3", kw_q.size()); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (res_q.size() !== 0 || cif.err !== 1'b0) begin
         errors++; $display("FAIL midrst_quiet: res %0d err %b want 0 0", res_q.size(), cif.err); end
      run_job(1'b0, 2'd0, 8'd1, 4, 1'b0, 1'b0, -1);
      checks++; if (res_q.size() !== 1 || n_cfg !== 1) begin
         errors++; $display("FAIL midrst_fresh: res %0d cfg %0d want 1 1", res_q.size(), n_cfg); end
      if (res_q.size() == 1) begin
         checks++; if (res_q[0] !== exp_q[0] || last_q[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_data: got %h/%b want %h/1", res_q[0], last_q[0], exp_q[0]); end
      end
   endtask

   task test_nblk255();
      int nlast;
      run_job(1'b0, 2'd0, 8'd255, 2, 1'b0, 1'b0, -1);
      nlast = 0;
      foreach (last_q[i]) if (last_q[i]) nlast++;
      checks++; if (res_q.size() !== 255) begin errors++; $display("FAIL n255_res: got %0d want 255", res_q.size()); end
      checks++; if (nlast !== 1 || (last_q.size() == 255 && last_q[254] !== 1'b1)) begin
         errors++; $display("FAIL n255_last: count %0d want 1 on block 255", nlast); end
      checks++; if (res_q.size() == 255 && res_q[254] !== exp_q[254]) begin
         errors++; $display("FAIL n255_data: got %h want %h", res_q[254], exp_q[254]); end
      checks++; if (cif.err !== 1'b0 || cif.busy !== 1'b0) begin
         errors++; $display("FAIL n255_end: err %b busy %b want 0 0", cif.err, cif.busy); end
   endtask

   task test_timeout();
      int t;
      int n;
      @(posedge clk); #1;
      tif.cmd_valid = 1'b1; tif.cmd_nk = 2'd0; tif.cmd_nblk = 8'd1;
      @(posedge clk); #1;
      tif.cmd_valid = 1'b0;
      tif.key_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tif.key_w = $urandom;
         t = 0;
         do begin @(negedge clk); t++; end while (!tif.key_ready && t < 50);
         if (!tif.key_ready) bound_fail("to_key");
         @(posedge clk); #1;
      end
      tif.key_valid = 1'b0;
      n = 0;
      do begin @(posedge clk); n++; @(negedge clk); end while (tif.busy && n < 40);
      checks++; if (n !== 15) begin errors++; $display("FAIL timeout_cycles: got %0d want 15", n); end
      checks++; if (tif.err !== 1'b1 || tif.cmd_ready !== 1'b1) begin
         errors++; $display("FAIL timeout_err: err %b cmd_ready %b want 1 1", tif.err, tif.cmd_ready); end
   endtask

   initial begin
      cif.cmd_valid = 1'b0; cif.cmd_inv = 1'b0; cif.cmd_nk = 2'd0; cif.cmd_nblk = 8'd0;
      cif.key_valid = 1'b0; cif.key_w = 32'd0; cif.blk_valid = 1'b0; cif.blk_data = '0;
      cif.aes_key_expand_done = 1'b0; cif.aes_out_pct_valid = 1'b0;
      cif.aes_out_pct_last_flag = 1'b0; cif.aes_out_pct = '0;
      tif.cmd_valid = 1'b0; tif.cmd_inv = 1'b0; tif.cmd_nk = 2'd0; tif.cmd_nblk = 8'd0;
      tif.key_valid = 1'b0; tif.key_w = 32'd0; tif.blk_valid = 1'b0; tif.blk_data = '0;
      tif.aes_key_expand_done = 1'b0; tif.aes_out_pct_valid = 1'b0;
      tif.aes_out_pct_last_flag = 1'b0; tif.aes_out_pct = '0;
      clear_mon();
      test_reset();
      test_basic();
      test_key_only();
      test_bad_nk();
      test_stray();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_nblk255();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/aes_seq_ctrl.md
AES_SEQ_CTRL -- requirements
Module: aes_seq_ctrl

Interface
REQ-001 SHALL have parameter KE_TIMEOUT, default 1023, meaning max cycles waited for key-expansion done before error.
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: cmd_valid/cmd_ready  in/out  1/1  job command handshake.
REQ-005 SHALL have ports: cmd_inv  in  1  decrypt when 1; cmd_nk  in  2  key size code (0=4 words, 1=6, 2=8, 3=reserved); cmd_nblk  in  8  block count (0 = key load only).
REQ-006 SHALL have ports: key_valid/key_ready  in/out  1/1, key_w  in  32  key word stream, word 0 first.
REQ-007 SHALL have ports: blk_valid/blk_ready  in/out  1/1, blk_data  in  128  input block stream.
REQ-008 SHALL have ports: res_valid  out  1, res_last  out  1, res_data  out  128  result stream, no backpressure.
REQ-009 SHALL have ports: busy  out  1, err  out  1  sticky error.
REQ-010 SHALL have core-side ports: aes_inv_valid, aes_inv, aes_nk_valid, aes_nk[2], aes_key_expand, aes_key_valid, aes_key_w[32], aes_pct_first_flag, aes_pct[128] (out); aes_key_expand_done, aes_out_pct_valid, aes_out_pct_last_flag, aes_out_pct[128] (in).

Function
REQ-011 SHALL implement FSM states IDLE, CFG, KSTART, KLOAD, KWAIT, RUN, DRAIN.
REQ-012 IDLE: cmd_ready=1; on cmd_valid latch inv, nk, nblk, clear err; nk=3 -> set err, stay IDLE, no core signals driven; else -> CFG.
REQ-013 CFG: aes_inv_valid=aes_nk_valid=1 for exactly one cycle with latched values -> KSTART.
REQ-014 KSTART: aes_key_expand=1 for one cycle -> KLOAD.
REQ-015 KLOAD: key_ready=1; each key handshake drives aes_key_valid=1, aes_key_w=key_w in the same cycle (combinational pass-through); after 4/6/8 words -> KWAIT.
REQ-016 KWAIT: count cycles; aes_key_expand_done=1 -> RUN if nblk!=0 else IDLE; count reaching KE_TIMEOUT -> set err, IDLE.
REQ-017 RUN: at most one block in flight; blk_ready=1 only when none in flight and issued<nblk.
REQ-018 Block handshake SHALL register blk_data into aes_pct (held until next accept) and assert aes_pct_first_flag for one cycle, one cycle after the handshake.
REQ-019 Result capture: aes_out_pct_valid && aes_out_pct_last_flag -> res_valid=1 one cycle, res_data=aes_out_pct (registered, 1-cycle latency), clear in-flight.
REQ-020 res_last=1 with the result of block number nblk; then -> IDLE.
REQ-021 Issued/completed counters SHALL be 8 bits; nblk=255 completes without wrap.
REQ-022 Core result while nothing in flight SHALL be ignored and set err.
REQ-023 cmd_ready=0 and busy=1 in every state except IDLE; commands outside IDLE not accepted.
REQ-024 DRAIN reserved for result pending after final issue; RUN -> DRAIN when issued==nblk, DRAIN -> IDLE on final result.

Reset
REQ-025 rst SHALL asynchronously force IDLE, zero all counters, all outputs 0 except cmd_ready=1.
REQ-026 rst mid-job SHALL abandon job; no res_valid until a new command completes.

Verification
REQ-027 cmd nk=0 inv=0 nblk=2, 4 key words, done after 20 cycles, 2 blocks -> one CFG pulse, 4 aes_key_valid, 2 res_valid, res_last on second.
REQ-028 cmd nk=2 nblk=0, 8 words, done -> returns IDLE, no blk_ready, no res_valid, err=0.
REQ-029 cmd nk=3 -> err=1, no aes_* pulses, cmd_ready stays 1; next valid cmd clears err.
REQ-030 KE_TIMEOUT=15, done never asserted -> err=1 and IDLE after 15 KWAIT cycles.
REQ-031 blk_valid held high during RUN -> second block accepted only after first result; cmd_valid during RUN ignored.
REQ-032 rst asserted in KLOAD after 3 words -> immediate IDLE, outputs zero, fresh job runs normally.
